// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: serial note-on/off events, lowest-free allocation,
// oldest-voice stealing by LRU rank, with popcount of the active-voice mask.

package voice_alloc_pkg;
  localparam int OSC_VOICES = 4;
endpackage

// Population count of a bit vector.
module bitcount #(
  parameter int W = 4
) (
  input  logic [W-1:0]           bits,
  output logic [$clog2(W+1)-1:0] count
);
  localparam int CW = $clog2(W+1);

  // Sum of set bits.
  always_comb begin
    count = {CW{1'b0}};
    for (int i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end
endmodule

module voice_alloc
  import voice_alloc_pkg::*;
#(
  parameter int VOICES = OSC_VOICES,
  parameter int NOTE_W = 7
) (
  input  logic                       clk_i,
  input  logic                       nrst_i,
  input  logic                       note_on_i,
  input  logic                       note_off_i,
  input  logic [NOTE_W-1:0]          note_i,
  output logic                       ready_o,
  output logic [VOICES-1:0]          voice_en_o,
  output logic [VOICES*NOTE_W-1:0]   voice_note_o,
  output logic [VOICES-1:0]          trig_o,
  output logic                       stolen_o,
  output logic [$clog2(VOICES+1)-1:0] active_cnt_o
);
  localparam int RW = $clog2(VOICES);
  localparam int CW = $clog2(VOICES+1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                     state_r;
  logic                       ready_r;
  logic [VOICES-1:0]          voice_en_r;
  logic [VOICES*NOTE_W-1:0]   voice_note_r;
  logic [VOICES-1:0]          trig_r;
  logic                       stolen_r;
  logic [CW-1:0]              active_cnt_r;
  logic [RW-1:0]              rank_r [VOICES];

  logic [NOTE_W-1:0]          note_r;
  logic                       is_off_r;
  logic [RW-1:0]              idx_r;
  logic                       match_found_r;
  logic [RW-1:0]              match_idx_r;
  logic                       free_found_r;
  logic [RW-1:0]              free_idx_r;
  logic [RW-1:0]              old_idx_r;

  logic [NOTE_W-1:0]          note_arr_s [VOICES];
  logic [RW-1:0]              tgt_s;
  logic [RW-1:0]              tgt_rank_s;
  logic                       alloc_s;
  logic [VOICES-1:0]          en_nxt_s;
  logic [VOICES*NOTE_W-1:0]   note_nxt_s;
  logic [RW-1:0]              rank_nxt_s [VOICES];
  logic [VOICES-1:0]          trig_nxt_s;
  logic                       stolen_nxt_s;
  logic [CW-1:0]              cnt_nxt_s;

  assign ready_o      = ready_r;
  assign voice_en_o   = voice_en_r;
  assign voice_note_o = voice_note_r;
  assign trig_o       = trig_r;
  assign stolen_o     = stolen_r;
  assign active_cnt_o = active_cnt_r;

  // Unpack the note fields for per-voice indexing during the scan.
  always_comb begin
    for (int v = 0; v < VOICES; v++) begin
      note_arr_s[v] = voice_note_r[v*NOTE_W +: NOTE_W];
    end
  end

  // Commit target: the matching voice first, then the lowest free one, else the oldest.
  always_comb begin
    alloc_s = 1'b0;
    if (is_off_r) begin
      tgt_s = match_idx_r;
    end else if (match_found_r) begin
      tgt_s = match_idx_r;
    end else if (free_found_r) begin
      tgt_s   = free_idx_r;
      alloc_s = 1'b1;
    end else begin
      tgt_s = old_idx_r;
    end
    tgt_rank_s = rank_r[tgt_s];
  end

  // Next-state voice table applied at the COMMIT edge.
  always_comb begin
    en_nxt_s     = voice_en_r;
    note_nxt_s   = voice_note_r;
    trig_nxt_s   = {VOICES{1'b0}};
    stolen_nxt_s = 1'b0;
    for (int v = 0; v < VOICES; v++) begin
      rank_nxt_s[v] = rank_r[v];
    end

    if (is_off_r) begin
      if (match_found_r) begin
        en_nxt_s[tgt_s] = 1'b0;
        for (int v = 0; v < VOICES; v++) begin
          if (voice_en_r[v] && (rank_r[v] > tgt_rank_s)) begin
            rank_nxt_s[v] = rank_r[v] - 1'b1;
          end else begin
            rank_nxt_s[v] = rank_r[v];
          end
        end
      end else begin
        en_nxt_s = voice_en_r;
      end
    end else begin
      // An allocation ages every active voice; a retrigger or steal only ages voices newer than the target.
      for (int v = 0; v < VOICES; v++) begin
        if (voice_en_r[v] && (alloc_s || (rank_r[v] < tgt_rank_s))) begin
          rank_nxt_s[v] = rank_r[v] + 1'b1;
        end else begin
          rank_nxt_s[v] = rank_r[v];
        end
      end
      rank_nxt_s[tgt_s] = {RW{1'b0}};
      en_nxt_s[tgt_s]   = 1'b1;
      trig_nxt_s[tgt_s] = 1'b1;
      stolen_nxt_s      = !match_found_r && !free_found_r;
      for (int v = 0; v < VOICES; v++) begin
        if (RW'(v) == tgt_s) begin
          note_nxt_s[v*NOTE_W +: NOTE_W] = note_r;
        end else begin
          note_nxt_s[v*NOTE_W +: NOTE_W] = voice_note_r[v*NOTE_W +: NOTE_W];
        end
      end
    end

    for (int v = 0; v < VOICES; v++) begin
      if (!en_nxt_s[v]) begin
        rank_nxt_s[v] = {RW{1'b0}};
      end else begin
        rank_nxt_s[v] = rank_nxt_s[v];
      end
    end
  end

  bitcount #(.W(VOICES)) u_bitcount (
    .bits  (en_nxt_s),
    .count (cnt_nxt_s)
  );

  // Allocator FSM with all registered outputs.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_r       <= IDLE;
      ready_r       <= 1'b1;
      voice_en_r    <= {VOICES{1'b0}};
      voice_note_r  <= {(VOICES*NOTE_W){1'b0}};
      trig_r        <= {VOICES{1'b0}};
      stolen_r      <= 1'b0;
      active_cnt_r  <= {CW{1'b0}};
      note_r        <= {NOTE_W{1'b0}};
      is_off_r      <= 1'b0;
      idx_r         <= {RW{1'b0}};
      match_found_r <= 1'b0;
      match_idx_r   <= {RW{1'b0}};
      free_found_r  <= 1'b0;
      free_idx_r    <= {RW{1'b0}};
      old_idx_r     <= {RW{1'b0}};
      for (int v = 0; v < VOICES; v++) begin
        rank_r[v] <= {RW{1'b0}};
      end
    end else begin
      trig_r   <= {VOICES{1'b0}};
      stolen_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (note_on_i || note_off_i) begin
            note_r        <= note_i;
            is_off_r      <= note_off_i;
            idx_r         <= {RW{1'b0}};
            match_found_r <= 1'b0;
            free_found_r  <= 1'b0;
            ready_r       <= 1'b0;
            state_r       <= SCAN;
          end else begin
            ready_r <= 1'b1;
            state_r <= IDLE;
          end
        end
        SCAN: begin
          if (voice_en_r[idx_r] && (note_arr_s[idx_r] == note_r)) begin
            match_found_r <= 1'b1;
            match_idx_r   <= idx_r;
          end else begin
            match_found_r <= match_found_r;
          end
          if (!voice_en_r[idx_r] && !free_found_r) begin
            free_found_r <= 1'b1;
            free_idx_r   <= idx_r;
          end else begin
            free_found_r <= free_found_r;
          end
          if (voice_en_r[idx_r] && (rank_r[idx_r] == RW'(VOICES-1))) begin
            old_idx_r <= idx_r;
          end else begin
            old_idx_r <= old_idx_r;
          end
          if (idx_r == RW'(VOICES-1)) begin
            state_r <= COMMIT;
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end
        COMMIT: begin
          voice_en_r   <= en_nxt_s;
          voice_note_r <= note_nxt_s;
          trig_r       <= trig_nxt_s;
          stolen_r     <= stolen_nxt_s;
          active_cnt_r <= cnt_nxt_s;
          for (int v = 0; v < VOICES; v++) begin
            rank_r[v] <= rank_nxt_s[v];
          end
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc with VOICES=4, NOTE_W=7 and hand-computed expectations.

module tb_voice_alloc;
  logic        clk_i = 1'b0;
  logic        nrst_i;
  logic        note_on_i;
  logic        note_off_i;
  logic [6:0]  note_i;
  logic        ready_o;
  logic [3:0]  voice_en_o;
  logic [27:0] voice_note_o;
  logic [3:0]  trig_o;
  logic        stolen_o;
  logic [2:0]  active_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] prev_en;

  voice_alloc #(.VOICES(4), .NOTE_W(7)) dut (
    .clk_i        (clk_i),
    .nrst_i       (nrst_i),
    .note_on_i    (note_on_i),
    .note_off_i   (note_off_i),
    .note_i       (note_i),
    .ready_o      (ready_o),
    .voice_en_o   (voice_en_o),
    .voice_note_o (voice_note_o),
    .trig_o       (trig_o),
    .stolen_o     (stolen_o),
    .active_cnt_o (active_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] notes(input logic [6:0] n3, input logic [6:0] n2,
                                        input logic [6:0] n1, input logic [6:0] n0);
    return {n3, n2, n1, n0};
  endfunction

  task automatic run_event(input string tag, input logic on, input logic off, input logic [6:0] n,
                           input logic [3:0] exp_en, input logic [3:0] exp_trig,
                           input logic exp_stolen, input logic [2:0] exp_cnt,
                           input logic [27:0] exp_notes, input logic glitch);
    int low;
    @(negedge clk_i);
    check_val({tag, "_ready_pre"}, 32'(ready_o), 32'd1);
    note_on_i  = on;
    note_off_i = off;
    note_i     = n;
    @(posedge clk_i);
    #1;
    note_on_i  = 1'b0;
    note_off_i = 1'b0;
    check_val({tag, "_en_scan"}, 32'(voice_en_o), 32'(prev_en));
    if (glitch) begin
      note_on_i = 1'b1;
      note_i    = 7'd90;
    end
    low = 0;
    while (ready_o == 1'b0 && low < 20) begin
      low++;
      @(posedge clk_i);
      #1;
      note_on_i = 1'b0;
    end
    check_val({tag, "_busy_cycles"}, 32'(low), 32'd5);
    check_val({tag, "_en"}, 32'(voice_en_o), 32'(exp_en));
    check_val({tag, "_trig"}, 32'(trig_o), 32'(exp_trig));
    check_val({tag, "_stolen"}, 32'(stolen_o), 32'(exp_stolen));
    check_val({tag, "_cnt"}, 32'(active_cnt_o), 32'(exp_cnt));
    check_val({tag, "_notes"}, 32'(voice_note_o), 32'(exp_notes));
    @(posedge clk_i);
    #1;
    check_val({tag, "_trig_end"}, 32'(trig_o), 32'd0);
    check_val({tag, "_stolen_end"}, 32'(stolen_o), 32'd0);
    check_val({tag, "_ready_post"}, 32'(ready_o), 32'd1);
    prev_en = exp_en;
  endtask

  initial begin
    nrst_i     = 1'b0;
    note_on_i  = 1'b0;
    note_off_i = 1'b0;
    note_i     = 7'd0;
    prev_en    = 4'b0000;
    #12;
    check_val("rst_en", 32'(voice_en_o), 32'd0);
    check_val("rst_notes", 32'(voice_note_o), 32'd0);
    check_val("rst_trig", 32'(trig_o), 32'd0);
    check_val("rst_stolen", 32'(stolen_o), 32'd0);
    check_val("rst_cnt", 32'(active_cnt_o), 32'd0);
    check_val("rst_ready", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    nrst_i = 1'b1;

    run_event("on60", 1'b1, 1'b0, 7'd60, 4'b0001, 4'b0001, 1'b0, 3'd1, notes(7'd0, 7'd0, 7'd0, 7'd60), 1'b0);
    run_event("on62", 1'b1, 1'b0, 7'd62, 4'b0011, 4'b0010, 1'b0, 3'd2, notes(7'd0, 7'd0, 7'd62, 7'd60), 1'b0);
    run_event("on64", 1'b1, 1'b0, 7'd64, 4'b0111, 4'b0100, 1'b0, 3'd3, notes(7'd0, 7'd64, 7'd62, 7'd60), 1'b0);
    run_event("on65", 1'b1, 1'b0, 7'd65, 4'b1111, 4'b1000, 1'b0, 3'd4, notes(7'd65, 7'd64, 7'd62, 7'd60), 1'b0);
    run_event("steal67", 1'b1, 1'b0, 7'd67, 4'b1111, 4'b0001, 1'b1, 3'd4, notes(7'd65, 7'd64, 7'd62, 7'd67), 1'b0);
    run_event("retrig62", 1'b1, 1'b0, 7'd62, 4'b1111, 4'b0010, 1'b0, 3'd4, notes(7'd65, 7'd64, 7'd62, 7'd67), 1'b0);
    run_event("steal70", 1'b1, 1'b0, 7'd70, 4'b1111, 4'b0100, 1'b1, 3'd4, notes(7'd65, 7'd70, 7'd62, 7'd67), 1'b0);
    run_event("off65", 1'b0, 1'b1, 7'd65, 4'b0111, 4'b0000, 1'b0, 3'd3, notes(7'd65, 7'd70, 7'd62, 7'd67), 1'b0);
    run_event("off99", 1'b0, 1'b1, 7'd99, 4'b0111, 4'b0000, 1'b0, 3'd3, notes(7'd65, 7'd70, 7'd62, 7'd67), 1'b0);
    run_event("on72", 1'b1, 1'b0, 7'd72, 4'b1111, 4'b1000, 1'b0, 3'd4, notes(7'd72, 7'd70, 7'd62, 7'd67), 1'b0);
    run_event("onoff72", 1'b1, 1'b1, 7'd72, 4'b0111, 4'b0000, 1'b0, 3'd3, notes(7'd72, 7'd70, 7'd62, 7'd67), 1'b0);
    run_event("on80_busyreq", 1'b1, 1'b0, 7'd80, 4'b1111, 4'b1000, 1'b0, 3'd4, notes(7'd80, 7'd70, 7'd62, 7'd67), 1'b1);

    // Reset asserted in the middle of a scan drops the event.
    @(negedge clk_i);
    note_on_i = 1'b1;
    note_i    = 7'd100;
    @(posedge clk_i);
    #1;
    note_on_i = 1'b0;
    check_val("midscan_accept", 32'(ready_o), 32'd0);
    @(posedge clk_i);
    #2;
    nrst_i = 1'b0;
    #1;
    check_val("midrst_en", 32'(voice_en_o), 32'd0);
    check_val("midrst_notes", 32'(voice_note_o), 32'd0);
    check_val("midrst_cnt", 32'(active_cnt_o), 32'd0);
    check_val("midrst_trig", 32'(trig_o), 32'd0);
    check_val("midrst_ready", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    nrst_i = 1'b1;
    repeat (8) @(negedge clk_i);
    check_val("postrst_en", 32'(voice_en_o), 32'd0);
    check_val("postrst_trig", 32'(trig_o), 32'd0);
    check_val("postrst_ready", 32'(ready_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/voice_alloc.md
# voice_alloc

Polyphonic voice allocator for the oscillator bank. It takes serialized note-on and note-off events and assigns each note to one of `OSC_VOICES` oscillator voices. When all voices are busy, it steals the least-recently-triggered voice. It drives the per-voice enable mask, note numbers and retrigger pulses into the oscillator bank, and reports the active-voice count using the existing `bitcount` block.

## Interface
- `VOICES`, default `OSC_VOICES`: number of voices; must be ≥2.
- `NOTE_W`, default 7: note number width (MIDI range).
- `clk_i`  in  1  system clock.
- `nrst_i`  in  1  reset; one clock, asynchronous, active-low.
- `note_on_i`  in  1  note-on request valid.
- `note_off_i`  in  1  note-off request valid.
- `note_i`  in  NOTE_W  note number of the request.
- `ready_o`  out  1  allocator idle; an event is accepted on an edge where `ready_o` and (`note_on_i` or `note_off_i`) are both high.
- `voice_en_o`  out  VOICES  active-voice mask, registered.
- `voice_note_o`  out  VOICES*NOTE_W  note per voice; voice v occupies bits [v*NOTE_W +: NOTE_W].
- `trig_o`  out  VOICES  one-cycle retrigger pulse (phase reset) to the committed voice.
- `stolen_o`  out  1  one-cycle pulse when a note-on stole an active voice.
- `active_cnt_o`  out  $clog2(VOICES+1)  popcount of `voice_en_o`, registered.

## Operation
- FSM states: IDLE, SCAN, COMMIT. `ready_o` is high only in IDLE.
- **IDLE**
  - On accept, latch `note_i` and the event type, then go to SCAN with idx=0.
  - Both `note_on_i` and `note_off_i` high means note-off; the note-on is discarded.
  - Requests while `ready_o`=0 are ignored; the requester must hold them until accepted.
- **SCAN**
  - Examines one voice per cycle, idx 0..VOICES-1, and records three things:
    - match: an active voice holding the latched note.
    - free: the lowest-index inactive voice.
    - oldest: the active voice with rank VOICES-1.
  - After idx=VOICES-1, go to COMMIT.
- **COMMIT** (one cycle, then IDLE)
  - Note-on with match: retrigger that voice.
  - Note-on, no match, free found: allocate the free voice, set its note.
  - Note-on, no match, no free: steal the oldest voice, overwrite its note, pulse `stolen_o`.
  - Note-on commits pulse the target's `trig_o` bit.
  - Note-off with match: clear the voice's enable bit. Its note field is kept.
  - Note-off without match: no state change, no pulses.
- **Rank (LRU) rules**
  - Each voice has a rank register, $clog2(VOICES) bits. Active voices hold distinct ranks 0..n-1, where 0 is newest.
  - Allocate: all active ranks +1, target rank 0.
  - Steal or retrigger of the target with rank r: active voices with rank < r get +1, target rank 0.
  - Release of rank r: active voices with rank > r get −1.
  - Inactive voices' ranks are don't-care and are forced to 0.
- **Invariant**: at most one active voice per note number.
- `active_cnt_o` is the registered output of a `bitcount` instance on the next-state mask. It updates on the same edge as `voice_en_o`.

## Timing
- **Reset** (asynchronous, `nrst_i`=0):
  - Outputs: `voice_en_o`=0, `voice_note_o`=0, `trig_o`=0, `stolen_o`=0, `active_cnt_o`=0.
  - Internal: all ranks 0, FSM in IDLE, so `ready_o`=1.
- **Reset mid-SCAN or mid-COMMIT**: the event is dropped, with no partial update.
- **Latency**: event accepted at edge k; SCAN occupies edges k+1..k+VOICES; the COMMIT update lands at edge k+VOICES+1.
- **Ready window**: `ready_o` is low for exactly VOICES+1 cycles per accepted event. The next accept is possible at edge k+VOICES+2.
- **Pulses**: `trig_o` and `stolen_o` are high for exactly the one cycle following the COMMIT edge, and low otherwise.
- **Stable registers**: `voice_en_o`, `voice_note_o` and `active_cnt_o` change only at the COMMIT edge.

## Test plan
All scenarios use VOICES=4, NOTE_W=7.
1. Reset asserted mid-cycle → all outputs 0 immediately, `ready_o`=1. Release reset, then hold `note_on_i` → accepted on the first edge.
2. Note-on 60, 62, 64 → voices 0, 1, 2 enabled (`voice_en_o`=0111). `trig_o` pulses 0001, 0010, 0100. `active_cnt_o`=3. `ready_o` low for 5 cycles per event.
3. Then note-on 65 (mask 1111, count 4), then note-on 67 → voice 0 (note 60, oldest) stolen. `voice_note_o[0]`=67, `stolen_o`=1 for one cycle, `trig_o`=0001, count stays 4.
4. Note-on 62 (already on voice 1) → retrigger: `trig_o`=0010, mask unchanged, no steal. The following note-on 70 steals voice 2 (note 64).
5. Note-off 65 → voice 3 cleared, count −1. Note-off 99 → no change, no pulses. Note-on 72 → fills voice 3.
6. `note_on_i` and `note_off_i` high together for note 72 → treated as note-off. A request raised while `ready_o`=0 causes no change.
